// File: rtl/cpu_pkg.sv
// Shared CPU pipeline types: memory-stage state encoding, load/store size codes
// and the natural-alignment predicate used by the optional alignment check.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
        case (funct3)
            F3_H, F3_HU: return offset[0];
            F3_W:        return offset != 2'b00;
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Picks the byte/half/word at the captured offset out of a read word and
// sign- or zero-extends it according to funct3.
module mem_load_align
    import cpu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[{offset, 3'b000} +: 8];
        // Halfwords only look at offset[1]; an odd halfword offset rounds down.
        half_sel = offset[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   data = {24'd0, byte_sel};
            F3_H:    data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   data = {16'd0, half_sel};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// M-stage data-memory controller: one req/ack transaction per load or store.
// Define MEM_ALIGN_CHECK_EN to trap misaligned H/W accesses instead of issuing them.
module mem_stage_ctrl
    import cpu_pkg::*;
#(
    parameter int MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m_MemRead,
    input  logic        m_MemWrite,
    input  logic [2:0]  m_funct3,
    input  logic [31:0] m_alu_out,
    input  logic [31:0] m_mem_data,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic [31:0] m_load_data,
    output logic        m_load_valid,
    output logic        bus_err,
    output logic        misalign_err
);

    // state | meaning
    // IDLE  | no access in flight; issues the request when a load/store arrives
    // WAIT  | request outstanding, counting cycles toward the bus timeout
    // DONE  | access retired; load result and error pulses visible, pipeline advances

    localparam logic [7:0] CNT_TC = 8'(MAX_WAIT - 1);

    mem_state_t  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] word_q;
    logic [1:0]  off_q;
    logic [2:0]  f3_q;
    logic        ld_q, bus_err_q, mis_err_q;
    logic        pending, misaligned, req, stall, capture, timeout, mis_hit;

    assign pending = m_MemRead | m_MemWrite;

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = is_misaligned(m_funct3, m_alu_out[1:0]);
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req     = 1'b0;
        stall   = 1'b0;
        capture = 1'b0;
        timeout = 1'b0;
        mis_hit = 1'b0;
        case (state_q)
            IDLE: begin
                if (pending) begin
                    stall = 1'b1;
                    if (misaligned) begin
                        mis_hit = 1'b1;
                        state_d = DONE;
                    end else begin
                        req = 1'b1;
                        if (dmem_ack) begin
                            capture = 1'b1;
                            state_d = DONE;
                        end else begin
                            state_d = WAIT;
                            cnt_d   = 8'd1;
                        end
                    end
                end
            end
            WAIT: begin
                stall = 1'b1;
                req   = 1'b1;
                if (dmem_ack) begin
                    capture = 1'b1;
                    state_d = DONE;
                end else if (cnt_q >= CNT_TC) begin
                    timeout = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 8'd0;
            word_q    <= 32'd0;
            off_q     <= 2'd0;
            f3_q      <= F3_B;
            ld_q      <= 1'b0;
            bus_err_q <= 1'b0;
            mis_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bus_err_q <= timeout;
            mis_err_q <= mis_hit;
            if (capture | timeout | mis_hit) begin
                ld_q <= m_MemRead;
            end
            // Stores leave the load path untouched so m_load_data keeps its value.
            if (m_MemRead && (capture | timeout | mis_hit)) begin
                word_q <= capture ? dmem_rdata : 32'd0;
                off_q  <= m_alu_out[1:0];
                f3_q   <= m_funct3;
            end
        end
    end

    mem_load_align u_load_align (
        .word   (word_q),
        .offset (off_q),
        .funct3 (f3_q),
        .data   (m_load_data)
    );

    assign dmem_req     = req & ~rst;
    assign mem_stall    = stall & ~rst;
    assign dmem_we      = dmem_req & m_MemWrite;
    assign dmem_addr    = {m_alu_out[31:2], 2'b00};
    assign m_load_valid = (state_q == DONE) & ld_q;
    assign bus_err      = (state_q == DONE) & bus_err_q;
    assign misalign_err = (state_q == DONE) & mis_err_q;

    always_comb begin
        dmem_be    = 4'b1111;
        dmem_wdata = m_mem_data;
        case (m_funct3)
            F3_B: begin
                dmem_wdata = {4{m_mem_data[7:0]}};
                if (m_MemWrite) dmem_be = 4'b0001 << m_alu_out[1:0];
            end
            F3_H: begin
                dmem_wdata = {2{m_mem_data[15:0]}};
                if (m_MemWrite) dmem_be = 4'b0011 << {m_alu_out[1], 1'b0};
            end
            default: begin
                dmem_wdata = m_mem_data;
            end
        endcase
    end

endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Memory-stage access controller for the 5-stage CPU pipeline, downstream of the EX/MEM pipeline register. It consumes that register's memory control and datapath outputs (MemRead, MemWrite, ALU address, store data, access size) and runs one request/acknowledge transaction per load or store on the data-memory port. It stalls the pipeline while the access is outstanding, generates byte enables and the aligned store data, and returns sign- or zero-extended load data to the MEM/WB stage.

## Interface
- MAX_WAIT, default 255: cycles waited for `dmem_ack` before a bus-timeout error; range 1..255.
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- m_MemRead  in  1  load in M stage
- m_MemWrite  in  1  store in M stage; never asserted together with `m_MemRead`
- m_funct3  in  3  access size/sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
- m_alu_out  in  32  byte address
- m_mem_data  in  32  store data, right-justified
- dmem_req  out  1  request valid
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word address, with `[1:0]` forced to 0
- dmem_wdata  out  32  lane-replicated store data
- dmem_be  out  4  byte enables
- dmem_ack  in  1  access complete; `dmem_rdata` valid in the same cycle
- dmem_rdata  in  32  read word
- mem_stall  out  1  freezes IF..EX/MEM while high
- m_load_data  out  32  extended load result
- m_load_valid  out  1  `m_load_data` valid this cycle
- bus_err  out  1  one-cycle pulse on timeout
- misalign_err  out  1  one-cycle pulse on a misaligned access; tied 0 when the alignment check is compiled out

## Operation
- Access pending = `m_MemRead | m_MemWrite`.
- State IDLE:
  - pending → assert `dmem_req` and `mem_stall`.
  - `dmem_ack` → capture data, go to DONE.
  - no ack → go to WAIT, with the wait counter set to 1.
- State WAIT:
  - Hold `dmem_req` and all `dmem_*` stable; `mem_stall` = 1.
  - `dmem_ack` → capture data, go to DONE.
  - Counter reaches MAX_WAIT → go to DONE with `bus_err` pulse and captured word = 0.
  - Otherwise increment the counter.
- State DONE:
  - `dmem_req` = 0, `mem_stall` = 0, `m_load_valid` = 1 for loads.
  - Go to IDLE unconditionally. The EX/MEM register advances at the end of this cycle, so no instruction is issued twice.
- Store byte enables and data:
  - SB: be = 0001 << a[1:0], wdata = {4{d[7:0]}}.
  - SH: be = 0011 << {a[1],1'b0}, wdata = {2{d[15:0]}}.
  - SW: be = 1111, wdata = d.
- Reads: `dmem_be` = 1111.
- Load extraction: from the captured word, the registered `a[1:0]`, and the registered funct3. The byte or half at the offset is sign-extended (LB/LH) or zero-extended (LBU/LHU); LW passes the word through.
- Outputs outside DONE: `m_load_data` holds its last value; `m_load_valid` = 0.

## Timing
- Zero-wait memory (ack in the IDLE cycle): instruction occupies M for 2 cycles (1 stall cycle + DONE).
- N wait cycles: instruction occupies M for N+2 cycles.
- `dmem_*` outputs are combinational from state and the held EX/MEM inputs. The inputs are stable while stalled.
- Error pulses (`bus_err`, `misalign_err`) assert during the DONE cycle.
- Reset:
  - State → IDLE; counter → 0.
  - `dmem_req`, `mem_stall`, `m_load_valid`, `bus_err`, `misalign_err` → 0; `m_load_data` → 0.
  - Reset mid-WAIT abandons the request; any late `dmem_ack` is ignored in IDLE unless a new request is pending.
- Ack in DONE is ignored.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined:
  - Misaligned accesses are never issued: LH/LHU/SH with `a[0]` = 1, or LW/SW with `a[1:0]` ≠ 0.
  - IDLE goes directly to DONE with no `dmem_req` (1 stall cycle), `misalign_err` pulse, and load data 0.
- `MEM_ALIGN_CHECK_EN` undefined:
  - No check; `misalign_err` = 0.
  - Halfword offset uses `a[1]` only; word accesses ignore `a[1:0]`.

## Structure
- Shared `cpu_pkg` holds:
  - `mem_state_t` enum (IDLE, WAIT, DONE).
  - funct3 constants `F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`.
- Sub-module `mem_load_align`: combinational word/offset/funct3 → extended load data.

## Test plan
- LW at 0x100, ack same cycle, rdata 0xDEADBEEF → `mem_stall` high for 1 cycle; next cycle `m_load_valid` = 1, `m_load_data` = 0xDEADBEEF.
- LB at 0x103 with rdata 0x80112233 → 0xFFFFFF80; LBU → 0x00000080; LHU at 0x102 → 0x00008011.
- SH at 0x202, data 0x0000ABCD → `dmem_addr` = 0x200, `dmem_be` = 1100, `dmem_wdata` = 0xABCDABCD, `dmem_we` = 1.
- LW with ack after 3 cycles → `dmem_req` and outputs stable for 4 cycles; 5 cycles in M total; single request observed.
- MAX_WAIT = 4, no ack → `bus_err` pulses in cycle 5, `m_load_data` = 0; assert `rst` mid-WAIT → next cycle `dmem_req` = 0, state IDLE.
- `MEM_ALIGN_CHECK_EN`: LW at 0x101 → no `dmem_req`, `misalign_err` pulse, 1 stall cycle.
